// File: rtl/mont_operand_feeder.sv
// Operand feeder for a radix-16 Montgomery multiplier: captures A/B/M and feeds gated multiples to the adder.
// Latency: start -> PREP next cycle; ITER x (PREP,ACC) pairs, 6 FINAL cycles, up to MAX_SUB 6-cycle SUB passes, 1 DONE cycle.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while a run is in progress.
module mont_operand_feeder #(
  parameter int ITER    = 128,
  parameter int MAX_SUB = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [511:0] in_a,
  input  logic [511:0] in_b,
  input  logic [511:0] in_m,
  input  logic         cZero,
  input  logic         cOne,
  input  logic         cTwo,
  input  logic         cThree,
  input  logic         carry,
  output logic [511:0] B0,
  output logic [512:0] B1,
  output logic [513:0] B2,
  output logic [514:0] B3,
  output logic [511:0] M0,
  output logic [512:0] M1,
  output logic [513:0] M2,
  output logic [514:0] M3,
  output logic [512:0] subtraction,
  output logic         c_doubleshift,
  output logic         subtract,
  output logic [3:0]   showFluffyPonies,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int IW = $clog2(ITER + 1);
  localparam int PW = $clog2(MAX_SUB + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ACC   = 3'd2,
    FINAL = 3'd3,
    SUB   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t         state;
  logic [511:0]   aReg;
  logic [511:0]   bReg;
  logic [511:0]   mReg;
  logic [IW-1:0]  iterCnt;
  logic [PW-1:0]  passCnt;
  logic [3:0]     stage;
  logic           errorReg;
  logic [IW-1:0]  iterNext;
  logic [PW-1:0]  passNext;

  assign iterNext = iterCnt + IW'(1);
  assign passNext = passCnt + PW'(1);

  // Main sequencer: operand capture, digit extraction, iteration/stage/pass counting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      aReg     <= '0;
      bReg     <= '0;
      mReg     <= '0;
      iterCnt  <= '0;
      passCnt  <= '0;
      stage    <= '0;
      errorReg <= 1'b0;
      B0       <= '0;
      B1       <= '0;
      B2       <= '0;
      B3       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aReg     <= in_a;
            bReg     <= in_b;
            mReg     <= in_m;
            iterCnt  <= '0;
            passCnt  <= '0;
            stage    <= '0;
            errorReg <= 1'b0;
            state    <= PREP;
          end
        end
        PREP: begin
          // Lowest A digit selects which shifted copies of B the adder sees in ACC.
          B0    <= aReg[0] ? bReg : '0;
          B1    <= aReg[1] ? {bReg, 1'b0} : '0;
          B2    <= aReg[2] ? {bReg, 2'b0} : '0;
          B3    <= aReg[3] ? {bReg, 3'b0} : '0;
          aReg  <= aReg >> 4;
          state <= ACC;
        end
        ACC: begin
          iterCnt <= iterNext;
          if (iterNext == IW'(ITER)) begin
            B0    <= '0;
            B1    <= '0;
            B2    <= '0;
            B3    <= '0;
            stage <= '0;
            state <= FINAL;
          end else begin
            state <= PREP;
          end
        end
        FINAL: begin
          if (stage == 4'd5) begin
            stage <= '0;
            state <= SUB;
          end else begin
            stage <= stage + 4'd1;
          end
        end
        SUB: begin
          // The adder's finish indication only counts at the end of a pass.
          if (stage == 4'd5) begin
            stage <= '0;
            if (carry) begin
              state <= DONE;
            end else if (passNext == PW'(MAX_SUB)) begin
              errorReg <= 1'b1;
              state    <= DONE;
            end else begin
              passCnt <= passNext;
            end
          end else begin
            stage <= stage + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Quotient-digit multiples of M follow the adder's carry-save bits within the ACC cycle.
  always_comb begin
    M0 = '0;
    M1 = '0;
    M2 = '0;
    M3 = '0;
    if (state == ACC) begin
      M0 = cZero  ? mReg : '0;
      M1 = cOne   ? {mReg, 1'b0} : '0;
      M2 = cTwo   ? {mReg, 2'b0} : '0;
      M3 = cThree ? {mReg, 3'b0} : '0;
    end
  end

  // Status and strobes decode straight from the registered state, so they are glitch-free and
  // collapse to zero the instant reset forces IDLE.
  always_comb begin
    subtraction      = (state == IDLE) ? '0 : ~{1'b0, mReg};
    c_doubleshift    = (state == ACC);
    subtract         = (state == SUB);
    showFluffyPonies = stage;
    busy             = (state != IDLE) && (state != DONE);
    done             = (state == DONE);
    error            = errorReg;
  end

endmodule

// File: tb/tb_mont_operand_feeder.sv
// Randomized bench for mont_operand_feeder against a run-position reference model.
// Latency: checks every cycle of each run, sampled mid-cycle after the falling edge.
// Backpressure: n/a; start is held or pulsed per scenario.
module tb_mont_operand_feeder;
  localparam int ITER    = 128;
  localparam int MAX_SUB = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [511:0] in_a, in_b, in_m;
  logic         cZero, cOne, cTwo, cThree, carry;
  logic [511:0] B0;
  logic [512:0] B1;
  logic [513:0] B2;
  logic [514:0] B3;
  logic [511:0] M0;
  logic [512:0] M1;
  logic [513:0] M2;
  logic [514:0] M3;
  logic [512:0] subtraction;
  logic         c_doubleshift, subtract, busy, done, error;
  logic [3:0]   showFluffyPonies;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mont_operand_feeder #(.ITER(ITER), .MAX_SUB(MAX_SUB)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .cZero(cZero), .cOne(cOne), .cTwo(cTwo), .cThree(cThree), .carry(carry),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3),
    .M0(M0), .M1(M1), .M2(M2), .M3(M3),
    .subtraction(subtraction), .c_doubleshift(c_doubleshift), .subtract(subtract),
    .showFluffyPonies(showFluffyPonies), .busy(busy), .done(done), .error(error)
  );

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives one complete operation and checks every cycle. The model works from the position t
  // within the run: 2*ITER cycles of PREP/ACC pairs, 6 FINAL stages, then 6-stage SUB passes.
  // carryPass: SUB pass whose stage 5 sees carry=1 (>= MAX_SUB means never).
  // abortAt: return at the start of cycle t (negative = never). Starts and ends on a falling edge.
  task automatic drive_run(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                           input int carryPass, input int abortAt, input bit holdStart);
    int passes, lastT, i, k, pass, stg;
    bit expErr, isAcc, isSub;
    logic [3:0]   d;
    logic [511:0] eB0, eM0;
    logic [512:0] eB1, eM1, eSubtr;
    logic [513:0] eB2, eM2;
    logic [514:0] eB3, eM3;
    logic [8:0]   eCtrl, aCtrl;
    logic [3:0]   eSfp;
    logic         eCds, eSubt, eBusy, eDone, eErr;
    passes = (carryPass < MAX_SUB) ? carryPass + 1 : MAX_SUB;
    expErr = (carryPass >= MAX_SUB);
    lastT  = 2*ITER + 6 + 6*passes;
    in_a = a; in_b = b; in_m = m; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = holdStart;
    for (int t = 0; t <= lastT + 1; t++) begin
      if (t == abortAt) return;
      d = 4'd0; isAcc = 1'b0; isSub = 1'b0; stg = 0; pass = 0;
      eCds = 0; eSubt = 0; eSfp = 4'd0; eBusy = 0; eDone = 0; eErr = 0;
      if (t < 2*ITER) begin
        i = t / 2;
        isAcc = (t % 2) == 1;
        if (isAcc)      d = a[4*i +: 4];
        else if (i > 0) d = a[4*(i-1) +: 4];
        eCds = isAcc; eBusy = 1;
      end else if (t < 2*ITER + 6) begin
        eSfp = 4'(t - 2*ITER); eBusy = 1;
      end else if (t < lastT) begin
        k = t - 2*ITER - 6; pass = k / 6; stg = k % 6; isSub = 1'b1;
        eSfp = 4'(stg); eSubt = 1; eBusy = 1;
      end else if (t == lastT) begin
        eDone = 1; eErr = expErr;
      end else begin
        eErr = expErr;
      end
      {cZero, cOne, cTwo, cThree} = 4'($urandom);
      carry = 1'($urandom);
      if (isSub && stg == 5) carry = (pass == carryPass);
      #1;
      eB0 = d[0] ? b : '0;
      eB1 = d[1] ? {b, 1'b0} : '0;
      eB2 = d[2] ? {b, 2'b0} : '0;
      eB3 = d[3] ? {b, 3'b0} : '0;
      eM0 = (isAcc && cZero)  ? m : '0;
      eM1 = (isAcc && cOne)   ? {m, 1'b0} : '0;
      eM2 = (isAcc && cTwo)   ? {m, 2'b0} : '0;
      eM3 = (isAcc && cThree) ? {m, 3'b0} : '0;
      eSubtr = (t <= lastT) ? ~{1'b0, m} : '0;
      eCtrl = {eCds, eSubt, eSfp, eBusy, eDone, eErr};
      aCtrl = {c_doubleshift, subtract, showFluffyPonies, busy, done, error};
      checks += 10;
      if (B0 !== eB0) begin errors++; $display("FAIL B0 t=%0d got %h exp %h", t, B0, eB0); end
      if (B1 !== eB1) begin errors++; $display("FAIL B1 t=%0d got %h exp %h", t, B1, eB1); end
      if (B2 !== eB2) begin errors++; $display("FAIL B2 t=%0d got %h exp %h", t, B2, eB2); end
      if (B3 !== eB3) begin errors++; $display("FAIL B3 t=%0d got %h exp %h", t, B3, eB3); end
      if (M0 !== eM0) begin errors++; $display("FAIL M0 t=%0d got %h exp %h", t, M0, eM0); end
      if (M1 !== eM1) begin errors++; $display("FAIL M1 t=%0d got %h exp %h", t, M1, eM1); end
      if (M2 !== eM2) begin errors++; $display("FAIL M2 t=%0d got %h exp %h", t, M2, eM2); end
      if (M3 !== eM3) begin errors++; $display("FAIL M3 t=%0d got %h exp %h", t, M3, eM3); end
      if (subtraction !== eSubtr) begin
        errors++; $display("FAIL subtraction t=%0d got %h exp %h", t, subtraction, eSubtr);
      end
      if (aCtrl !== eCtrl) begin
        errors++;
        $display("FAIL ctrl{cds,sub,sfp,busy,done,err} t=%0d got %b exp %b", t, aCtrl, eCtrl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; carry = 1'b0;
    in_a = rand512(); in_b = rand512(); in_m = rand512() | 512'd1;
    {cZero, cOne, cTwo, cThree} = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 10;
    if (B0 !== '0) begin errors++; $display("FAIL reset_B0 got %h exp 0", B0); end
    if (B1 !== '0) begin errors++; $display("FAIL reset_B1 got %h exp 0", B1); end
    if (B2 !== '0) begin errors++; $display("FAIL reset_B2 got %h exp 0", B2); end
    if (B3 !== '0) begin errors++; $display("FAIL reset_B3 got %h exp 0", B3); end
    if (M0 !== '0) begin errors++; $display("FAIL reset_M0 got %h exp 0", M0); end
    if (M1 !== '0) begin errors++; $display("FAIL reset_M1 got %h exp 0", M1); end
    if (M2 !== '0) begin errors++; $display("FAIL reset_M2 got %h exp 0", M2); end
    if (M3 !== '0) begin errors++; $display("FAIL reset_M3 got %h exp 0", M3); end
    if (subtraction !== '0) begin errors++; $display("FAIL reset_subtraction got %h exp 0", subtraction); end
    if ({c_doubleshift, subtract, showFluffyPonies, busy, done, error} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000000",
               {c_doubleshift, subtract, showFluffyPonies, busy, done, error});
    end
    resetn = 1'b1;
  endtask

  // a=5, b=1, m=0xB: B0=1, B2=4 in the first ACC; carry on the second SUB pass.
  task automatic test_known_vector();
    drive_run(512'h5, 512'h1, 512'hB, 1, -1, 1'b0);
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 3; r++)
      drive_run(rand512(), rand512(), rand512() | 512'd1, int'($urandom_range(0, MAX_SUB-1)), -1, 1'b0);
  endtask

  // carry never arrives: MAX_SUB passes then error; the next start must clear error.
  task automatic test_error();
    drive_run(rand512(), rand512(), rand512() | 512'd1, MAX_SUB, -1, 1'b0);
    drive_run(rand512(), rand512(), rand512() | 512'd1, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    drive_run(rand512(), rand512(), rand512() | 512'd1, 0, 2*60 + 1, 1'b0);
    {cZero, cOne, cTwo, cThree} = 4'hF;
    #1;
    checks++;
    if (c_doubleshift !== 1'b1) begin errors++; $display("FAIL midrun_in_acc got %b exp 1", c_doubleshift); end
    resetn = 1'b0;
    #1;
    checks += 3;
    if ({M0, B0} !== '0) begin errors++; $display("FAIL async_reset_M0B0 got %h exp 0", {M0, B0}); end
    if (subtraction !== '0) begin errors++; $display("FAIL async_reset_subtraction got %h exp 0", subtraction); end
    if ({c_doubleshift, subtract, showFluffyPonies, busy, done, error} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset_ctrl got %b exp 000000000",
               {c_doubleshift, subtract, showFluffyPonies, busy, done, error});
    end
    @(negedge clk);
    resetn = 1'b1;
    drive_run(rand512(), rand512(), rand512() | 512'd1, 2, -1, 1'b0);
  endtask

  // start stuck high: exactly one run, then a fresh run right after the IDLE cycle that follows DONE.
  task automatic test_start_held();
    drive_run(rand512(), rand512(), rand512() | 512'd1, 0, -1, 1'b1);
    #1;
    checks++;
    if ({busy, c_doubleshift, done} !== 3'b100) begin
      errors++; $display("FAIL restart_after_idle {busy,cds,done} got %b exp 100", {busy, c_doubleshift, done});
    end
    start = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_random_runs();
    test_error();
    test_reset_mid_run();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mont_operand_feeder.md
MONT_OPERAND_FEEDER -- requirements
Module: mont_operand_feeder

Interface
REQ-001 SHALL have parameter ITER, default 128, meaning radix-16 iterations per multiplication (512/4).
REQ-002 SHALL have parameter MAX_SUB, default 4, meaning the maximum number of subtract passes before the error flag is raised.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a request sampled only in IDLE.
REQ-006 SHALL have ports in_a, in_b and in_m, input, 512 each, the multiplier, multiplicand and odd modulus.
REQ-007 SHALL have ports cZero, cOne, cTwo and cThree, input, 1 each, the low carry-save digit bits from the adder.
REQ-008 SHALL have port carry, input, 1, the adder's subtract-finished indication.
REQ-009 SHALL have ports B0/B1/B2/B3, output, 512/513/514/515, the gated multiples a_k*(B<<k), k=0..3.
REQ-010 SHALL have ports M0/M1/M2/M3, output, 512/513/514/515, the gated multiples q_k*(M<<k), k=0..3.
REQ-011 SHALL have port subtraction, output, 513, the bitwise inverse of {1'b0,M}.
REQ-012 SHALL have ports c_doubleshift and subtract, output, 1 each, the adder control strobes.
REQ-013 SHALL have port showFluffyPonies, output, 4, the adder chunk-stage index 0..5.
REQ-014 SHALL have ports busy, done and error, output, 1 each, the status flags.

Function
REQ-015 SHALL be a five-state FSM: IDLE, PREP, ACC, FINAL, SUB, plus DONE.
REQ-016 IDLE: start=1 SHALL capture in_a, in_b and in_m into internal registers, clear the iteration counter and go to PREP; busy SHALL be 1 from the next cycle.
REQ-017 PREP (1 cycle): SHALL register B0..B3 from A-register bits [3:0], shift the A register right by 4, and go to ACC.
REQ-018 ACC (1 cycle): c_doubleshift SHALL be 1; Mk SHALL equal M<<k when the matching c-bit (cZero..cThree for k=0..3) is 1, else 0, purely combinational from the c-bits in that cycle.
REQ-019 Outside ACC, M0..M3 SHALL be 0.
REQ-020 ACC SHALL increment the iteration counter; if the counter now equals ITER, go to FINAL, else go to PREP; one iteration = 2 cycles, so 256 cycles for ITER=128.
REQ-021 FINAL: subtract=0; showFluffyPonies SHALL step 0,1,2,3,4,5 on consecutive cycles, then go to SUB with the stage reset to 0; B0..B3 SHALL be 0.
REQ-022 SUB: subtract=1; showFluffyPonies SHALL step 0..5 repeatedly.
REQ-023 SUB: carry=1 at stage 5 SHALL go to DONE.
REQ-024 SUB: at stage 5 with carry=0, the pass counter SHALL increment; reaching MAX_SUB SHALL set error=1 and go to DONE.
REQ-025 SUB: carry sampled at any stage other than 5 SHALL be ignored.
REQ-026 DONE (1 cycle): done=1, busy=0, then go to IDLE; error SHALL hold until the next accepted start.
REQ-027 subtraction SHALL be driven from the captured M and be stable from PREP to DONE.
REQ-028 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-029 c_doubleshift and subtract SHALL never be 1 in the same cycle.
REQ-030 showFluffyPonies SHALL be 0 in IDLE, PREP and ACC.

Reset
REQ-031 resetn=0 SHALL, at any time including mid-ACC or mid-SUB, immediately force IDLE and clear all operand registers and counters.
REQ-032 During and after resetn=0, every output SHALL be 0: B*, M*, subtraction, c_doubleshift, subtract, showFluffyPonies, busy, done and error.
REQ-033 Operation SHALL resume on the first rising edge after resetn deasserts; start on that edge SHALL be accepted.

Verification
REQ-034 in_a=0x5, in_b=1, in_m=0xB, start pulse -> first PREP gives B0=1, B1=0, B2=4, B3=0; c_doubleshift is high on exactly 128 cycles, alternating with PREP.
REQ-035 In ACC with cZero=1, cTwo=1 and the other c-bits 0, in_m=0xB -> M0=0xB, M1=0, M2=0x2C, M3=0; in PREP all M*=0.
REQ-036 After the last ACC -> showFluffyPonies 0..5 with subtract=0; then subtract=1; carry=1 at stage 5 of the second pass -> done pulses 1 cycle later, error=0.
REQ-037 carry held 0 -> exactly 4 SUB passes (24 cycles), then error=1 and done=1.
REQ-038 resetn pulsed low at iteration 60 -> all outputs 0 asynchronously; a new start then yields a full 128-iteration run.
REQ-039 start held high through an entire run -> no second run; the next run begins only on the IDLE cycle after DONE.
